dispatch: RTL
=============

# dispatch

Dispatch stage directly downstream of rename. Accepts renamed uops over a valid/ready handshake and buffers them in a small in-order queue. Computes and snoops source-operand ready bits against a 128-entry physical-register busy table, then issues the head uop to the ROB and exactly one reservation station (ALU, branch or memory) in the same cycle. Flushes on mispredict.

## Interface
- DEPTH, 2: queue entries (power of two, ≥2)
- NPREG, 128: physical registers; preg index width is 7
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- valid_in  in  1  rename uop valid
- data_in  in  rename_data  renamed uop: pc, ps1, ps2, pd_old, pd_new, imm, rob_tag, fu, ALUOp, Opcode, func3, func7
- ready_in  out  1  queue can accept; registered, equals !full
- mispredict  in  1  flush request
- cdb_valid  in  1  writeback broadcast valid
- cdb_tag  in  7  physical register written back
- rob_ready  in  1  ROB can allocate this cycle
- rs_alu_ready, rs_br_ready, rs_mem_ready  in  1 each  RS has a free slot
- rob_alloc  out  1  ROB allocate strobe
- rs_alu_alloc, rs_br_alloc, rs_mem_alloc  out  1 each  RS allocate strobes, at most one high
- data_out  out  dispatch_data  head uop plus ps1_rdy, ps2_rdy

## Operation
- Push: valid_in && ready_in writes data_in at the tail.
- Ready bits at push: psX_rdy = (psX == 0) || !busy[psX] || (cdb_valid && cdb_tag == psX).
- Busy table: 128 bits, busy[0] hard-wired 0.
  - Push with pd_new != 0 sets busy[pd_new].
  - cdb_valid clears busy[cdb_tag].
  - If both hit the same index in one cycle, the set wins.
- Snoop: every cycle, each valid queue entry with psX == cdb_tag and cdb_valid sets psX_rdy to 1.
- Route by data_in.fu (fu_t):
  - FU_ALU → ALU RS.
  - FU_BR → branch RS; covers branch and jalr.
  - FU_MEM → memory RS.
  - Reserved encoding → ALU RS.
- Fire: fire = head_valid && rob_ready && rs_ready[head.fu].
  - rob_alloc = fire.
  - Only the routed rs_*_alloc is raised, equal to fire.
  - All strobes are combinational from queue state and ready inputs; none depend on valid_in.
- Pop on fire. Push and pop in the same cycle are allowed when not full; count is unchanged.
- data_out is the head entry, including ready bits as updated by snoops up to the previous edge.
  - data_out also ORs in the current-cycle CDB match, so a uop firing in the same cycle as its operand's writeback shows rdy=1.
- Mispredict, at the edge:
  - Count, head and tail go to 0; all strobes are low in that cycle.
  - valid_in is ignored in that cycle.
  - The busy table is not modified. Freed pregs are re-set on reallocation.

## Timing
- Reset values:
  - Queue empty, pointers 0, busy table all 0.
  - ready_in = 1; rob_alloc and all rs_*_alloc = 0; data_out = '0.
- Latency: a uop pushed at edge t can fire in cycle t+1 at the earliest.
- Throughput: 1 uop/cycle sustained when downstream stays ready.
- Full: ready_in = 0 when count == DEPTH. It rises the cycle after a pop.
- Empty: head_valid = 0, so no strobes.
- Pointers wrap modulo DEPTH.
- Backpressure stalls: the head holds with no strobes, and ready bits keep snooping.
- Reset mid-operation: immediate flush to reset state, regardless of clk.

## Structure
- types_pkg gains the following; rename_data and decode types are unchanged:
  - fu_t enum, 2 bits: FU_ALU=0, FU_BR=1, FU_MEM=2.
  - dispatch_data: rename_data plus ps1_rdy, ps2_rdy.
  - localparam PREG_W = 7.
- One sub-module, busy_table: 128-bit set/clear array with two combinational read ports (ps1, ps2) and a CDB bypass.
- The queue stays inline in dispatch.

## Test plan
- Reset then push an ALU uop {ps1=5, ps2=0, pd_new=40}, all ready → next cycle rob_alloc=1, rs_alu_alloc=1, ps1_rdy=1, ps2_rdy=1; busy[40]=1.
- Push uop B with ps1=40 while 40 is busy; cdb_valid with cdb_tag=40 two cycles later → B's ps1_rdy goes 0 then 1; busy[40] cleared.
- Hold rs_mem_ready=0 and push 2 FU_MEM uops → ready_in=0, no strobes; release → fires on 2 consecutive cycles; ready_in=1 after the first pop.
- Push pd_new=60 with cdb_tag=60 in the same cycle → busy[60]=1 (set wins).
- Fill the queue, assert mispredict → next cycle empty, ready_in=1, no strobes; a following push fires normally.
- Stream 8 uops alternating FU_ALU, FU_BR, FU_MEM with all readies high → one fire per cycle in order; routing correct; pointers wrap.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the rename/dispatch slice.
// Provides the renamed-uop record (rename_data), the dispatch output record
// (dispatch_data = rename_data plus source ready bits), the functional-unit
// routing enum and the physical-register index width.
package types_pkg;

    localparam int unsigned PREG_W    = 7;
    localparam int unsigned ROB_TAG_W = 5;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_BR  = 2'd1,
        FU_MEM = 2'd2
    } fu_t;

    typedef logic [3:0] alu_op_t;
    typedef logic [6:0] opcode_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [PREG_W-1:0]    ps1;
        logic [PREG_W-1:0]    ps2;
        logic [PREG_W-1:0]    pd_old;
        logic [PREG_W-1:0]    pd_new;
        logic [31:0]          imm;
        logic [ROB_TAG_W-1:0] rob_tag;
        fu_t                  fu;
        alu_op_t              ALUOp;
        opcode_t              Opcode;
        logic [2:0]           func3;
        logic [6:0]           func7;
    } rename_data;

    typedef struct packed {
        rename_data uop;
        logic       ps1_rdy;
        logic       ps2_rdy;
    } dispatch_data;

endpackage

// File: rtl/busy_table.sv
// Physical-register busy table.
// Ports:
//   clk, reset        clock, asynchronous active-high reset (all entries idle)
//   set_en, set_idx   mark a destination preg busy (wins over a same-index clear)
//   clr_en, clr_idx   writeback clears the preg's busy bit
//   rd_idx1/rd_idx2   two combinational read ports
//   rd_rdy1/rd_rdy2   operand ready: preg 0, not busy, or being written back now
module busy_table
    import types_pkg::*;
#(
    parameter int unsigned NPREG = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [PREG_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [PREG_W-1:0] clr_idx,
    input  logic [PREG_W-1:0] rd_idx1,
    input  logic [PREG_W-1:0] rd_idx2,
    output logic              rd_rdy1,
    output logic              rd_rdy2
);

    logic [NPREG-1:0] busy_q;
    logic [NPREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        // Reallocation of a preg being written back must leave it busy.
        if (set_en) busy_d[set_idx] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    // CDB bypass: a source written back this cycle is already ready.
    assign rd_rdy1 = (rd_idx1 == '0) || !busy_q[rd_idx1] || (clr_en && clr_idx == rd_idx1);
    assign rd_rdy2 = (rd_idx2 == '0) || !busy_q[rd_idx2] || (clr_en && clr_idx == rd_idx2);

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: in-order queue between rename and the ROB/reservation stations.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   valid_in, data_in, ready_in    rename handshake (ready_in registered, = !full)
//   mispredict                     flush queue at the edge
//   cdb_valid, cdb_tag             writeback broadcast (clears busy, snoops queue)
//   rob_ready, rs_*_ready          downstream capacity
//   rob_alloc, rs_*_alloc          allocate strobes for the head uop
//   data_out                       head uop with current operand ready bits
module dispatch
    import types_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned NPREG = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  rename_data        data_in,
    output logic              ready_in,
    input  logic              mispredict,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_tag,
    input  logic              rob_ready,
    input  logic              rs_alu_ready,
    input  logic              rs_br_ready,
    input  logic              rs_mem_ready,
    output logic              rob_alloc,
    output logic              rs_alu_alloc,
    output logic              rs_br_alloc,
    output logic              rs_mem_alloc,
    output dispatch_data      data_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rename_data       q_uop [DEPTH];
    logic [DEPTH-1:0] rdy1_q, rdy1_d;
    logic [DEPTH-1:0] rdy2_q, rdy2_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q;

    logic       push;
    logic       fire;
    logic       head_valid;
    logic       sel_ready;
    logic       is_br;
    logic       is_mem;
    logic       bt_rdy1;
    logic       bt_rdy2;
    rename_data head_uop;

    assign push       = valid_in && ready_q && !mispredict;
    assign head_valid = (count_q != '0);
    assign head_uop   = q_uop[head_q];

    busy_table #(
        .NPREG (NPREG)
    ) u_busy_table (
        .clk     (clk),
        .reset   (reset),
        .set_en  (push && (data_in.pd_new != '0)),
        .set_idx (data_in.pd_new),
        .clr_en  (cdb_valid),
        .clr_idx (cdb_tag),
        .rd_idx1 (data_in.ps1),
        .rd_idx2 (data_in.ps2),
        .rd_rdy1 (bt_rdy1),
        .rd_rdy2 (bt_rdy2)
    );

    // Routing; the reserved fu encoding falls through to the ALU station.
    always_comb begin
        is_br     = 1'b0;
        is_mem    = 1'b0;
        sel_ready = rs_alu_ready;
        case (head_uop.fu)
            FU_BR: begin
                is_br     = 1'b1;
                sel_ready = rs_br_ready;
            end
            FU_MEM: begin
                is_mem    = 1'b1;
                sel_ready = rs_mem_ready;
            end
            default: sel_ready = rs_alu_ready;
        endcase
    end

    assign fire         = head_valid && rob_ready && sel_ready && !mispredict;
    assign rob_alloc    = fire;
    assign rs_alu_alloc = fire && !is_br && !is_mem;
    assign rs_br_alloc  = fire && is_br;
    assign rs_mem_alloc = fire && is_mem;
    assign ready_in     = ready_q;

    always_comb begin
        data_out = '0;
        if (head_valid) begin
            data_out.uop     = head_uop;
            data_out.ps1_rdy = rdy1_q[head_q] || (cdb_valid && head_uop.ps1 == cdb_tag);
            data_out.ps2_rdy = rdy2_q[head_q] || (cdb_valid && head_uop.ps2 == cdb_tag);
        end
    end

    // Snoop every entry; stale entries outside the valid window are harmless.
    always_comb begin
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        if (cdb_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_uop[i].ps1 == cdb_tag) rdy1_d[i] = 1'b1;
                if (q_uop[i].ps2 == cdb_tag) rdy2_d[i] = 1'b1;
            end
        end
        if (push) begin
            rdy1_d[tail_q] = bt_rdy1;
            rdy2_d[tail_q] = bt_rdy2;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Power-of-two depth: pointer increment wraps naturally.
            if (push) tail_d = tail_q + 1'b1;
            if (fire) head_d = head_q + 1'b1;
            case ({push, fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(DEPTH));
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
        end
    end

    // Payload storage needs no reset: data_out is gated by head_valid.
    always_ff @(posedge clk) begin
        if (push) q_uop[tail_q] <= data_in;
    end

endmodule
